// File: rtl/conv_operand_feeder_if.sv
//------------------------------------------------------------------------------
// Module  : conv_operand_feeder_if
// Brief   : Operand stream, engine vector and result stream bundle of the feeder.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface conv_operand_feeder_if #(
    parameter int VEC_LEN = 64,
    parameter int DATA_W  = 16
);
    // Serial operand stream
    logic [DATA_W-1:0]         s_data;
    logic                      s_is_weight;
    logic                      s_valid;
    logic                      s_ready;
    // Engine operand vectors and result return
    logic [VEC_LEN*DATA_W-1:0] act_vec;
    logic [VEC_LEN*DATA_W-1:0] wgt_vec;
    logic                      eng_valid;
    logic                      eng_ready;
    logic [DATA_W-1:0]         eng_result;
    logic                      eng_result_valid;
    logic                      eng_result_ready;
    // Forwarded result stream
    logic [DATA_W-1:0]         m_data;
    logic                      m_valid;
    logic                      m_ready;

    modport master (
        input  s_data, s_is_weight, s_valid, eng_ready, eng_result,
               eng_result_valid, m_ready,
        output s_ready, act_vec, wgt_vec, eng_valid, eng_result_ready,
               m_data, m_valid
    );

    modport slave (
        output s_data, s_is_weight, s_valid, eng_ready, eng_result,
               eng_result_valid, m_ready,
        input  s_ready, act_vec, wgt_vec, eng_valid, eng_result_ready,
               m_data, m_valid
    );
endinterface

`default_nettype wire

// File: rtl/conv_operand_feeder.sv
//------------------------------------------------------------------------------
// Module  : conv_operand_feeder
// Brief   : Packs serial operands into activation/weight vectors, issues them
//           to the conv engine and forwards the scalar result downstream.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv_operand_feeder #(
    parameter int VEC_LEN = 64,
    parameter int DATA_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    conv_operand_feeder_if.master bus,
    output logic [15:0]           vec_count_o,
    output logic                  busy_o
);

    localparam int               PTR_W  = $clog2(VEC_LEN) + 1;
    localparam logic [PTR_W-1:0] C_FULL = PTR_W'(VEC_LEN);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                    state_q,     state_d;
    logic [PTR_W-1:0]          act_ptr_q,   act_ptr_d;
    logic [PTR_W-1:0]          wgt_ptr_q,   wgt_ptr_d;
    logic                      eng_valid_q, eng_valid_d;
    logic                      m_valid_q,   m_valid_d;
    logic [DATA_W-1:0]         m_data_q,    m_data_d;
    logic [15:0]               vec_count_q, vec_count_d;
    logic [VEC_LEN*DATA_W-1:0] act_vec_q;
    logic [VEC_LEN*DATA_W-1:0] wgt_vec_q;

    logic w_act_full;
    logic w_wgt_full;
    logic w_s_ready;
    logic w_act_wr;
    logic w_wgt_wr;

    // A word is only stalled when its own bank is full; the other bank keeps flowing.
    always_comb begin
        w_act_full = (act_ptr_q == C_FULL);
        w_wgt_full = (wgt_ptr_q == C_FULL);
        w_s_ready  = (state_q == ST_LOAD) &&
                     !(bus.s_is_weight ? w_wgt_full : w_act_full);
        w_act_wr   = w_s_ready && bus.s_valid && !bus.s_is_weight;
        w_wgt_wr   = w_s_ready && bus.s_valid &&  bus.s_is_weight;
    end

    always_comb begin
        state_d     = state_q;
        act_ptr_d   = act_ptr_q;
        wgt_ptr_d   = wgt_ptr_q;
        eng_valid_d = eng_valid_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        vec_count_d = vec_count_q;

        case (state_q)
            ST_LOAD: begin
                if (w_act_wr) begin
                    act_ptr_d = act_ptr_q + PTR_W'(1);
                end
                if (w_wgt_wr) begin
                    wgt_ptr_d = wgt_ptr_q + PTR_W'(1);
                end
                if (w_act_full && w_wgt_full) begin
                    state_d     = ST_ISSUE;
                    eng_valid_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (eng_valid_q && bus.eng_ready) begin
                    eng_valid_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.eng_result_valid) begin
                    m_data_d  = bus.eng_result;
                    m_valid_d = 1'b1;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Pointers clear only here, so the vectors stay stable until the result leaves.
                if (m_valid_q && bus.m_ready) begin
                    m_valid_d   = 1'b0;
                    act_ptr_d   = '0;
                    wgt_ptr_d   = '0;
                    vec_count_d = vec_count_q + 16'd1;
                    state_d     = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            act_ptr_q   <= '0;
            wgt_ptr_q   <= '0;
            eng_valid_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            act_ptr_q   <= act_ptr_d;
            wgt_ptr_q   <= wgt_ptr_d;
            eng_valid_q <= eng_valid_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            vec_count_q <= vec_count_d;
        end
    end

    // Vector banks are not cleared between operations; each new load overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_vec_q <= '0;
            wgt_vec_q <= '0;
        end else begin
            for (int i = 0; i < VEC_LEN; i++) begin
                if (w_act_wr && (act_ptr_q == PTR_W'(i))) begin
                    act_vec_q[i*DATA_W +: DATA_W] <= bus.s_data;
                end
                if (w_wgt_wr && (wgt_ptr_q == PTR_W'(i))) begin
                    wgt_vec_q[i*DATA_W +: DATA_W] <= bus.s_data;
                end
            end
        end
    end

    assign bus.s_ready          = w_s_ready;
    assign bus.act_vec          = act_vec_q;
    assign bus.wgt_vec          = wgt_vec_q;
    assign bus.eng_valid        = eng_valid_q;
    assign bus.eng_result_ready = (state_q == ST_WAIT);
    assign bus.m_data           = m_data_q;
    assign bus.m_valid          = m_valid_q;
    assign vec_count_o          = vec_count_q;
    assign busy_o               = (state_q != ST_LOAD) || (|act_ptr_q) || (|wgt_ptr_q);

endmodule

`default_nettype wire

// File: tb/tb_conv_operand_feeder.sv
//------------------------------------------------------------------------------
// Module  : tb_conv_operand_feeder
// Brief   : Randomized scoreboard bench for conv_operand_feeder.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_conv_operand_feeder;

    localparam int VL = 64;
    localparam int DW = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] vec_count;
    logic        busy;

    always #5 clk = ~clk;

    conv_operand_feeder_if #(.VEC_LEN(VL), .DATA_W(DW)) bus ();

    conv_operand_feeder #(.VEC_LEN(VL), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.master),
        .vec_count_o (vec_count),
        .busy_o      (busy)
    );

    typedef struct {
        logic [VL*DW-1:0] a;
        logic [VL*DW-1:0] w;
    } vec_pair_t;

    int          tests = 0;
    int          fails = 0;
    vec_pair_t   sb_vec[$];
    logic [DW-1:0] sb_res[$];
    logic [DW-1:0] act_m[$];
    logic [DW-1:0] wgt_m[$];
    logic [15:0] model_count = 16'd0;
    vec_pair_t   mon_pair;
    logic [DW-1:0] mon_res;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_vec(input string name, input logic [VL*DW-1:0] got,
                           input logic [VL*DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            for (int i = 0; i < VL; i++) begin
                if (got[i*DW +: DW] !== exp[i*DW +: DW]) begin
                    $display("FAIL %s: element %0d got 0x%0h expected 0x%0h at %0t",
                             name, i, got[i*DW +: DW], exp[i*DW +: DW], $time);
                    break;
                end
            end
        end
    endtask

    // Reference model: a batch is the first VL words of each kind since the last operation.
    function automatic void model_accept(input bit w, input logic [DW-1:0] d);
        vec_pair_t p;
        if (w) wgt_m.push_back(d);
        else   act_m.push_back(d);
        if (act_m.size() >= VL && wgt_m.size() >= VL) begin
            for (int i = 0; i < VL; i++) begin
                p.a[i*DW +: DW] = act_m.pop_front();
                p.w[i*DW +: DW] = wgt_m.pop_front();
            end
            sb_vec.push_back(p);
        end
    endfunction

    // Monitor: compares each handshake against the scoreboard heads.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.eng_valid && bus.eng_ready) begin
                if (sb_vec.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL eng_handshake_unexpected: got 1 expected 0 at %0t", $time);
                end else begin
                    mon_pair = sb_vec.pop_front();
                    chk_vec("act_vec_hs", bus.act_vec, mon_pair.a);
                    chk_vec("wgt_vec_hs", bus.wgt_vec, mon_pair.w);
                end
            end
            if (bus.m_valid && bus.m_ready) begin
                if (sb_res.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL m_handshake_unexpected: got 1 expected 0 at %0t", $time);
                end else begin
                    mon_res = sb_res.pop_front();
                    chk("m_data_hs", 64'(bus.m_data), 64'(mon_res));
                    chk("vec_count_pre", 64'(vec_count), 64'(model_count));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit w, input logic [DW-1:0] d);
        bus.s_is_weight = w;
        bus.s_data      = d;
        bus.s_valid     = 1'b1;
        #1;
        chk("s_ready_accept", 64'(bus.s_ready), 64'd1);
        model_accept(w, d);
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic probe(input bit w, input logic [DW-1:0] d);
        bus.s_is_weight = w;
        bus.s_data      = d;
        bus.s_valid     = 1'b1;
        #1;
        chk("s_ready_full", 64'(bus.s_ready), 64'd0);
        tick();
        chk("s_ready_full_hold", 64'(bus.s_ready), 64'd0);
        bus.s_valid = 1'b0;
    endtask

    task automatic do_reset_pulse();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        act_m.delete();
        wgt_m.delete();
        model_count = 16'd0;
        #1;
        chk("rst_eng_valid",        64'(bus.eng_valid), 64'd0);
        chk("rst_m_valid",          64'(bus.m_valid), 64'd0);
        chk("rst_m_data",           64'(bus.m_data), 64'd0);
        chk("rst_vec_count",        64'(vec_count), 64'd0);
        chk("rst_s_ready",          64'(bus.s_ready), 64'd1);
        chk("rst_eng_result_ready", 64'(bus.eng_result_ready), 64'd0);
        chk("rst_busy",             64'(busy), 64'd0);
        chk_vec("rst_act_vec", bus.act_vec, '0);
        chk_vec("rst_wgt_vec", bus.wgt_vec, '0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_op(input int mode, input int eng_dly, input int wait_dly,
                          input int m_dly, input logic [DW-1:0] res, input bit rst_in_wait);
        int na = 0;
        int nw = 0;
        int r;
        bit w;
        case (mode)
            0: begin
                for (int i = 0; i < VL; i++) begin
                    send(1'b0, DW'(i + 1));
                    send(1'b1, 16'h0002);
                end
            end
            1: begin
                for (int i = 0; i < VL; i++) send(1'b0, DW'($urandom));
                probe(1'b0, DW'($urandom));
                for (int i = 0; i < VL; i++) begin
                    send(1'b1, DW'($urandom));
                    if (i % 16 == 0) probe(1'b0, DW'($urandom));
                end
            end
            default: begin
                while (na < VL || nw < VL) begin
                    r = $urandom_range(0, 7);
                    if (r == 0) begin
                        bus.s_valid = 1'b0;
                        tick();
                    end else if (r == 1 && (na == VL || nw == VL)) begin
                        probe(na == VL ? 1'b0 : 1'b1, DW'($urandom));
                    end else begin
                        w = (na == VL) ? 1'b1 : (nw == VL) ? 1'b0 : 1'($urandom_range(0, 1));
                        send(w, DW'($urandom));
                        if (w) nw++;
                        else   na++;
                    end
                end
            end
        endcase

        chk("eng_valid_before", 64'(bus.eng_valid), 64'd0);
        chk("busy_loaded",      64'(busy), 64'd1);
        tick();
        chk("eng_valid_latency", 64'(bus.eng_valid), 64'd1);

        bus.eng_ready = 1'b0;
        repeat (eng_dly) begin
            bus.eng_result_valid = 1'($urandom_range(0, 1));
            bus.eng_result       = DW'($urandom);
            #1;
            chk("eng_valid_hold",     64'(bus.eng_valid), 64'd1);
            chk("m_valid_issue",      64'(bus.m_valid), 64'd0);
            chk("res_ready_issue",    64'(bus.eng_result_ready), 64'd0);
            if (sb_vec.size() > 0) begin
                chk_vec("act_vec_stable", bus.act_vec, sb_vec[0].a);
                chk_vec("wgt_vec_stable", bus.wgt_vec, sb_vec[0].w);
            end
            tick();
        end
        bus.eng_result_valid = 1'b0;
        bus.eng_ready        = 1'b1;
        tick();
        bus.eng_ready = 1'b0;
        #1;
        chk("eng_valid_drop",   64'(bus.eng_valid), 64'd0);
        chk("eng_result_ready", 64'(bus.eng_result_ready), 64'd1);

        if (rst_in_wait) begin
            bus.eng_result_valid = 1'b1;
            bus.eng_result       = DW'($urandom);
            do_reset_pulse();
            repeat (4) begin
                #1;
                chk("m_valid_after_rst", 64'(bus.m_valid), 64'd0);
                chk("busy_after_rst",    64'(busy), 64'd0);
                tick();
            end
            bus.eng_result_valid = 1'b0;
            return;
        end

        repeat (wait_dly) begin
            tick();
            chk("m_valid_wait", 64'(bus.m_valid), 64'd0);
        end
        bus.eng_result       = res;
        bus.eng_result_valid = 1'b1;
        sb_res.push_back(res);
        tick();
        bus.eng_result_valid = 1'b0;
        chk("m_valid_rise",        64'(bus.m_valid), 64'd1);
        chk("m_data_capture",      64'(bus.m_data), 64'(res));
        chk("res_ready_drain",     64'(bus.eng_result_ready), 64'd0);

        bus.m_ready = 1'b0;
        repeat (m_dly) begin
            tick();
            chk("m_valid_hold", 64'(bus.m_valid), 64'd1);
            chk("m_data_hold",  64'(bus.m_data), 64'(res));
            chk("s_ready_drain", 64'(bus.s_ready), 64'd0);
        end
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        model_count = model_count + 16'd1;
        chk("vec_count_after", 64'(vec_count), 64'(model_count));
        chk("m_valid_clear",   64'(bus.m_valid), 64'd0);
        chk("busy_idle",       64'(busy), 64'd0);
        chk("s_ready_reopen",  64'(bus.s_ready), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.s_data           = '0;
        bus.s_is_weight      = 1'b0;
        bus.s_valid          = 1'b0;
        bus.eng_ready        = 1'b0;
        bus.eng_result       = '0;
        bus.eng_result_valid = 1'b0;
        bus.m_ready          = 1'b0;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Partial load, then an asynchronous mid-cycle reset.
        for (int i = 0; i < 5; i++) send(1'b0, DW'($urandom | 1));
        chk("busy_partial", 64'(busy), 64'd1);
        do_reset_pulse();
        tick();

        run_op(0, 0, 0, 0, DW'($urandom), 1'b0);
        run_op(1, 5, 2, 3, 16'h1234, 1'b0);
        repeat (4) run_op(2, $urandom_range(0, 4), $urandom_range(0, 3),
                          $urandom_range(0, 3), DW'($urandom), 1'b0);

        force dut.vec_count_q = 16'hFFFF;
        tick();
        tick();
        release dut.vec_count_q;
        model_count = 16'hFFFF;
        tick();
        chk("vec_count_preload", 64'(vec_count), 64'hFFFF);
        run_op(2, 1, 1, 1, DW'($urandom), 1'b0);

        run_op(2, 0, 0, 0, DW'($urandom), 1'b1);
        chk("vec_count_after_wait_rst", 64'(vec_count), 64'd0);
        run_op(0, 2, 0, 1, DW'($urandom), 1'b0);

        repeat (3) tick();
        chk("sb_vec_drained", 64'(sb_vec.size()), 64'd0);
        chk("sb_res_drained", 64'(sb_res.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
